// File: rtl/m14k_rf_srs_ctl.sv
// Shadow register set sweep controller: initialises every implemented set after reset and
// optionally clears a single set on request (build with M14K_RF_SRS_CLEAR_EN).
module m14k_rf_srs_ctl #(
  parameter logic [31:0] INIT_DATA = 32'h0000_0000
) (
  input  logic        gclk,
  input  logic        greset,
  input  logic [3:0]  cfg_srs_num,
  input  logic        mpc_rfwrite_w,
  input  logic [8:0]  mpc_dest_w,
  input  logic [31:0] edp_wrdata_w,
  input  logic        clear_req,
  input  logic [3:0]  clear_set,
  output logic        clear_ack,
  output logic        clear_err,
  output logic        rf_write_en,
  output logic [8:0]  rf_dest,
  output logic [31:0] rf_wrdata,
  output logic        rf_init_done,
  output logic        srs_busy
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
`ifdef M14K_RF_SRS_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd2;
`endif

  logic [1:0] state_q, state_d;
  logic [3:0] set_q, set_d;
  logic [4:0] reg_q, reg_d;
  logic [3:0] cfg_max_q;
  logic       init_done_q, init_done_d;
  logic       sweeping, advance, last_reg;

`ifdef M14K_RF_SRS_CLEAR_EN
  logic ack_q, ack_d;
  logic err_q, err_d;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_set};
`endif

  assign sweeping = (state_q != S_IDLE);
  // Pipeline writes steal the port; the sweep pointer simply holds for that cycle.
  assign advance  = sweeping && !mpc_rfwrite_w;
  assign last_reg = (reg_q == 5'd31);

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    reg_d       = reg_q;
    init_done_d = init_done_q;
`ifdef M14K_RF_SRS_CLEAR_EN
    ack_d       = 1'b0;
    err_d       = 1'b0;
`endif
    if (advance) begin
      if (!last_reg) begin
        reg_d = reg_q + 5'd1;
      end else begin
        reg_d = 5'd1;
        if (state_q == S_INIT && set_q != cfg_max_q) begin
          set_d = set_q + 4'd1;
        end else begin
          state_d = S_IDLE;
          if (state_q == S_INIT) init_done_d = 1'b1;
`ifdef M14K_RF_SRS_CLEAR_EN
          else ack_d = 1'b1;
`endif
        end
      end
    end
`ifdef M14K_RF_SRS_CLEAR_EN
    // ack_q blocks re-acceptance while the requester is still dropping clear_req.
    else if (state_q == S_IDLE && clear_req && !ack_q) begin
      if (clear_set > cfg_max_q) begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end else begin
        state_d = S_CLEAR;
        set_d   = clear_set;
        reg_d   = 5'd1;
      end
    end
`endif
  end

  always_ff @(posedge gclk) begin
    if (greset) begin
      state_q     <= S_INIT;
      set_q       <= 4'd0;
      reg_q       <= 5'd1;
      cfg_max_q   <= cfg_srs_num;
      init_done_q <= 1'b0;
`ifdef M14K_RF_SRS_CLEAR_EN
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      reg_q       <= reg_d;
      init_done_q <= init_done_d;
`ifdef M14K_RF_SRS_CLEAR_EN
      ack_q       <= ack_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    rf_write_en = !greset && (mpc_rfwrite_w || sweeping);
    if (mpc_rfwrite_w) begin
      rf_dest   = mpc_dest_w;
      rf_wrdata = edp_wrdata_w;
    end else begin
      rf_dest   = {set_q, reg_q};
      rf_wrdata = INIT_DATA;
    end
  end

  assign rf_init_done = init_done_q;
  assign srs_busy     = sweeping;

`ifdef M14K_RF_SRS_CLEAR_EN
  assign clear_ack = ack_q;
  assign clear_err = err_q;
`else
  assign clear_ack = 1'b0;
  assign clear_err = 1'b0;
`endif

endmodule
